// File: rtl/pll_reset_sequencer_if.sv
// Board-side signals of the PLL reset sequencer: PLL lock/button in, staged resets and diagnostics out.
// All signals are static levels with no valid/ready pairing; inputs are asynchronous to the sequencer clock.
interface pll_reset_sequencer_if;
   logic       pll_locked_i;
   logic       btn_reset_i;
   logic       pll_rst_o;
   logic       periph_rst_n_o;
   logic       cpu_rst_n_o;
   logic [2:0] state_o;
   logic [7:0] relock_count_o;

   modport master (
      input  pll_locked_i,
      input  btn_reset_i,
      output pll_rst_o,
      output periph_rst_n_o,
      output cpu_rst_n_o,
      output state_o,
      output relock_count_o
   );

   modport slave (
      output pll_locked_i,
      output btn_reset_i,
      input  pll_rst_o,
      input  periph_rst_n_o,
      input  cpu_rst_n_o,
      input  state_o,
      input  relock_count_o
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, releases peripheral then CPU reset, restarts the PLL on lock timeout
// and counts lock losses seen while running.
module pll_reset_sequencer #(
   parameter int unsigned SYNC_STAGES         = 2,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned STAGE_GAP_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
   parameter int unsigned PLL_RST_CYCLES      = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   pll_reset_sequencer_if.master   bus
);

   localparam int unsigned MAX_AB = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                                    LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
   localparam int unsigned MAX_CD = (LOCK_TIMEOUT_CYCLES > PLL_RST_CYCLES) ?
                                    LOCK_TIMEOUT_CYCLES : PLL_RST_CYCLES;
   localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int          CNT_W  = $clog2(MAX_P + 1);

   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      STABLE     = 3'd1,
      REL_PERIPH = 3'd2,
      RUN        = 3'd3,
      PLL_RESET  = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
   logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   pll_rst_q, pll_rst_d;
   logic                   periph_rst_n_q, periph_rst_n_d;
   logic                   cpu_rst_n_q, cpu_rst_n_d;
   logic [7:0]             relock_q, relock_d;
   logic                   drop_q, drop_d;
   logic                   drop_loss_q, drop_loss_d;

   logic locked_s;
   logic btn_s;

   assign locked_s = lock_sync_q[SYNC_STAGES-1];
   assign btn_s    = btn_sync_q[SYNC_STAGES-1];

   always_comb begin
      lock_sync_d    = {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked_i};
      btn_sync_d     = {btn_sync_q[SYNC_STAGES-2:0], bus.btn_reset_i};
      state_d        = state_q;
      cnt_d          = cnt_q + CNT_W'(1);
      pll_rst_d      = pll_rst_q;
      periph_rst_n_d = periph_rst_n_q;
      cpu_rst_n_d    = cpu_rst_n_q;
      relock_d       = relock_q;
      drop_d         = 1'b0;
      drop_loss_d    = 1'b0;

      case (state_q)
         PLL_RESET: begin
            if (cnt_q == PLL_RST_LAST) begin
               state_d   = WAIT_LOCK;
               cnt_d     = '0;
               pll_rst_d = 1'b0;
            end
         end

         // A drop out of RUN is registered first and applied on the following edge;
         // drop_loss_q remembers whether it was a lock loss (counted) or the button (not counted).
         RUN: begin
            cnt_d = '0;
            if (drop_q) begin
               state_d        = WAIT_LOCK;
               periph_rst_n_d = 1'b0;
               cpu_rst_n_d    = 1'b0;
               if (drop_loss_q && (relock_q != 8'hFF)) begin
                  relock_d = relock_q + 8'd1;
               end
            end else if (btn_s) begin
               drop_d      = 1'b1;
               drop_loss_d = 1'b0;
            end else if (!locked_s) begin
               drop_d      = 1'b1;
               drop_loss_d = 1'b1;
            end
         end

         WAIT_LOCK, STABLE, REL_PERIPH: begin
            if (btn_s) begin
               state_d        = WAIT_LOCK;
               cnt_d          = '0;
               periph_rst_n_d = 1'b0;
               cpu_rst_n_d    = 1'b0;
               pll_rst_d      = 1'b0;
            end else if (state_q == WAIT_LOCK) begin
               if (locked_s) begin
                  state_d = STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d   = PLL_RESET;
                  cnt_d     = '0;
                  pll_rst_d = 1'b1;
               end
            end else if (!locked_s) begin
               state_d        = WAIT_LOCK;
               cnt_d          = '0;
               periph_rst_n_d = 1'b0;
               cpu_rst_n_d    = 1'b0;
            end else if ((state_q == STABLE) && (cnt_q == STABLE_LAST)) begin
               state_d        = REL_PERIPH;
               cnt_d          = '0;
               periph_rst_n_d = 1'b1;
            end else if ((state_q == REL_PERIPH) && (cnt_q == GAP_LAST)) begin
               state_d     = RUN;
               cnt_d       = '0;
               cpu_rst_n_d = 1'b1;
            end
         end

         default: begin
            state_d        = WAIT_LOCK;
            cnt_d          = '0;
            pll_rst_d      = 1'b0;
            periph_rst_n_d = 1'b0;
            cpu_rst_n_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_sync_q    <= '0;
         btn_sync_q     <= '0;
         state_q        <= WAIT_LOCK;
         cnt_q          <= '0;
         pll_rst_q      <= 1'b0;
         periph_rst_n_q <= 1'b0;
         cpu_rst_n_q    <= 1'b0;
         relock_q       <= 8'd0;
         drop_q         <= 1'b0;
         drop_loss_q    <= 1'b0;
      end else begin
         lock_sync_q    <= lock_sync_d;
         btn_sync_q     <= btn_sync_d;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         pll_rst_q      <= pll_rst_d;
         periph_rst_n_q <= periph_rst_n_d;
         cpu_rst_n_q    <= cpu_rst_n_d;
         relock_q       <= relock_d;
         drop_q         <= drop_d;
         drop_loss_q    <= drop_loss_d;
      end
   end

   assign bus.pll_rst_o      = pll_rst_q;
   assign bus.periph_rst_n_o = periph_rst_n_q;
   assign bus.cpu_rst_n_o    = cpu_rst_n_q;
   assign bus.state_o        = state_q;
   assign bus.relock_count_o = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed timing scenarios plus random lock/button traffic,
// checked every cycle against an elapsed-time reference model.
module tb_pll_reset_sequencer;

   localparam int SYNC = 2;
   localparam int LST  = 16;
   localparam int GAP  = 4;
   localparam int TMO  = 64;
   localparam int PRC  = 8;

   logic clk;
   logic reset_n;

   pll_reset_sequencer_if bus_if ();

   pll_reset_sequencer #(
      .SYNC_STAGES        (SYNC),
      .LOCK_STABLE_CYCLES (LST),
      .STAGE_GAP_CYCLES   (GAP),
      .LOCK_TIMEOUT_CYCLES(TMO),
      .PLL_RST_CYCLES     (PRC)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus_if)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard state
   int          n_vec;
   int          n_err;
   logic [13:0] exp_q[$];

   // reference model: phase code, edge at which the phase began, edge counter
   int m_phase;
   int m_start;
   int cyc;
   int m_count;
   bit m_pend;
   bit m_pend_loss;
   bit lock_hist[$];
   bit btn_hist[$];

   // observed event marks (edge numbers since reset release)
   int periph_rise_at, periph_fall_at, periph_rise_n;
   int cpu_rise_at, cpu_fall_at;
   int pll_rise_at, pll_fall_at;
   bit prev_periph, prev_cpu, prev_pll;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [13:0] exp_vec();
      logic       e_pll, e_per, e_cpu;
      logic [2:0] e_st;
      e_pll = (m_phase == 4);
      e_per = (m_phase == 2) || (m_phase == 3);
      e_cpu = (m_phase == 3);
      e_st  = 3'(m_phase);
      return {e_pll, e_per, e_cpu, e_st, 8'(m_count)};
   endfunction

   task automatic m_go(input int ph);
      m_phase = ph;
      m_start = cyc;
   endtask

   task automatic model_reset();
      m_phase     = 0;
      cyc         = 0;
      m_start     = 0;
      m_count     = 0;
      m_pend      = 1'b0;
      m_pend_loss = 1'b0;
      lock_hist.delete();
      btn_hist.delete();
      for (int i = 0; i < SYNC; i++) begin
         lock_hist.push_back(1'b0);
         btn_hist.push_back(1'b0);
      end
      exp_q.delete();
   endtask

   // One clock edge of the reference; lk/bt are the input values sampled at this edge.
   task automatic model_step(input bit lk, input bit bt);
      bit ls, bs;
      int el;
      cyc++;
      ls = lock_hist.pop_front();
      bs = btn_hist.pop_front();
      lock_hist.push_back(lk);
      btn_hist.push_back(bt);
      el = cyc - m_start;
      if (m_phase == 4) begin
         if (el == PRC) m_go(0);
      end else if (m_phase == 3) begin
         if (m_pend) begin
            if (m_pend_loss && m_count < 255) m_count++;
            m_pend = 1'b0;
            m_go(0);
         end else if (bs) begin
            m_pend = 1'b1; m_pend_loss = 1'b0;
         end else if (!ls) begin
            m_pend = 1'b1; m_pend_loss = 1'b1;
         end
      end else if (bs) begin
         m_go(0);
      end else if (m_phase == 0) begin
         if (ls) m_go(1);
         else if (el == TMO) m_go(4);
      end else if (!ls) begin
         m_go(0);
      end else if (m_phase == 1 && el == LST) begin
         m_go(2);
      end else if (m_phase == 2 && el == GAP) begin
         m_go(3);
      end
      exp_q.push_back(exp_vec());
   endtask

   task automatic marks_reset();
      periph_rise_at = -1; periph_fall_at = -1; periph_rise_n = 0;
      cpu_rise_at = -1; cpu_fall_at = -1;
      pll_rise_at = -1; pll_fall_at = -1;
      prev_periph = 1'b0; prev_cpu = 1'b0; prev_pll = 1'b0;
   endtask

   // driver: reset with inputs idle, released on a falling edge
   task automatic do_reset();
      reset_n = 1'b0;
      bus_if.pll_locked_i = 1'b0;
      bus_if.btn_reset_i  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      marks_reset();
   endtask

   // driver: one cycle; new input values take effect for the next edge
   task automatic tick(input bit nl, input bit nb);
      logic [13:0] obs;
      logic [13:0] exp;
      @(posedge clk);
      model_step(bus_if.pll_locked_i, bus_if.btn_reset_i);
      #2;
      bus_if.pll_locked_i = nl;
      bus_if.btn_reset_i  = nb;
      @(negedge clk);
      obs = {bus_if.pll_rst_o, bus_if.periph_rst_n_o, bus_if.cpu_rst_n_o,
             bus_if.state_o, bus_if.relock_count_o};
      if (exp_q.size() == 0) begin
         check("exp_queue_empty", 32'd1, 32'd0);
      end else begin
         exp = exp_q.pop_front();
         check("outs", 32'(obs), 32'(exp));
      end
      check("order", 32'(bus_if.cpu_rst_n_o & ~bus_if.periph_rst_n_o), 32'd0);
      if (bus_if.periph_rst_n_o && !prev_periph) begin
         periph_rise_at = cyc; periph_rise_n++;
      end
      if (!bus_if.periph_rst_n_o && prev_periph) periph_fall_at = cyc;
      if (bus_if.cpu_rst_n_o && !prev_cpu) cpu_rise_at = cyc;
      if (!bus_if.cpu_rst_n_o && prev_cpu) cpu_fall_at = cyc;
      if (bus_if.pll_rst_o && !prev_pll) pll_rise_at = cyc;
      if (!bus_if.pll_rst_o && prev_pll) pll_fall_at = cyc;
      prev_periph = bus_if.periph_rst_n_o;
      prev_cpu    = bus_if.cpu_rst_n_o;
      prev_pll    = bus_if.pll_rst_o;
   endtask

   initial begin
      int len;
      int r;
      bit lv;
      n_vec = 0;
      n_err = 0;

      // reset values
      do_reset();
      check("rst_pll", 32'(bus_if.pll_rst_o), 32'd0);
      check("rst_periph", 32'(bus_if.periph_rst_n_o), 32'd0);
      check("rst_cpu", 32'(bus_if.cpu_rst_n_o), 32'd0);
      check("rst_state", 32'(bus_if.state_o), 32'd0);
      check("rst_count", 32'(bus_if.relock_count_o), 32'd0);

      // clean lock, first sampled at edge 10
      for (int i = 1; i <= 40; i++) tick(i >= 9, 1'b0);
      check("clean_periph_rise", 32'(periph_rise_at), 32'd28);
      check("clean_cpu_rise", 32'(cpu_rise_at), 32'd32);
      check("clean_state_run", 32'(bus_if.state_o), 32'd3);

      // lock loss in RUN: low samples at edges 42..50, high again from 51
      for (int i = 41; i <= 79; i++) tick((i < 41) || (i >= 50), 1'b0);
      check("loss_periph_fall", 32'(periph_fall_at), 32'd45);
      check("loss_cpu_fall", 32'(cpu_fall_at), 32'd45);
      check("loss_count", 32'(bus_if.relock_count_o), 32'd1);
      check("relock_periph_rise", 32'(periph_rise_at), 32'd69);
      check("relock_cpu_rise", 32'(cpu_rise_at), 32'd73);

      // button held for samples 81..85 while running
      for (int i = 80; i <= 120; i++) tick(1'b1, (i >= 80) && (i < 85));
      check("btn_periph_fall", 32'(periph_fall_at), 32'd84);
      check("btn_cpu_fall", 32'(cpu_fall_at), 32'd84);
      check("btn_periph_rise", 32'(periph_rise_at), 32'd104);
      check("btn_cpu_rise", 32'(cpu_rise_at), 32'd108);
      check("btn_count_kept", 32'(bus_if.relock_count_o), 32'd1);

      // lock glitch: high samples 21..28, low at 29, high from 30
      do_reset();
      for (int i = 1; i <= 55; i++) tick((i >= 20) && (i != 28), 1'b0);
      check("glitch_periph_rise", 32'(periph_rise_at), 32'd48);
      check("glitch_single_release", 32'(periph_rise_n), 32'd1);

      // timeout and PLL restart pulse
      do_reset();
      for (int i = 1; i <= 70; i++) tick(1'b0, 1'b0);
      check("tmo_pll_rise", 32'(pll_rise_at), 32'd64);
      for (int i = 71; i <= 80; i++) tick(1'b0, 1'b0);
      check("tmo_pll_fall", 32'(pll_fall_at), 32'd72);
      for (int i = 81; i <= 140; i++) tick(1'b0, 1'b0);
      check("tmo_pll_rise2", 32'(pll_rise_at), 32'd136);
      check("tmo_periph_held", 32'(periph_rise_n), 32'd0);

      // async reset in the middle of the pll_rst_o pulse
      @(posedge clk);
      #3;
      check("async_pre_pll", 32'(bus_if.pll_rst_o), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_pll", 32'(bus_if.pll_rst_o), 32'd0);
      check("async_state", 32'(bus_if.state_o), 32'd0);
      check("async_resets", 32'({bus_if.periph_rst_n_o, bus_if.cpu_rst_n_o}), 32'd0);
      do_reset();

      // random lock / button traffic
      while (cyc < 4000) begin
         r = int'($urandom_range(0, 9));
         if (r < 5) begin
            len = int'($urandom_range(1, 60));
            repeat (len) tick(1'b1, 1'b0);
         end else if (r < 8) begin
            len = int'($urandom_range(1, 100));
            repeat (len) tick(1'b0, 1'b0);
         end else begin
            len = int'($urandom_range(1, 6));
            lv  = 1'($urandom_range(0, 1));
            repeat (len) tick(lv, 1'b1);
         end
      end

      // saturation of the relock counter
      do_reset();
      for (int k = 0; k < 260; k++) begin
         repeat (30) tick(1'b1, 1'b0);
         repeat (4) tick(1'b0, 1'b0);
      end
      check("sat_count", 32'(bus_if.relock_count_o), 32'd255);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset sequencer that sits directly downstream of the board PLL. It consumes the PLL's asynchronous lock indication and a user reset button, and qualifies lock stability before releasing staged, synchronous active-low resets (peripherals first, then CPU). It restarts the PLL through its RST input if lock is not reached within a timeout, and counts lock-loss events for diagnostics. It runs in the system clock domain fed by one PLL output.

## Interface
- SYNC_STAGES, 2: synchronizer depth for `pll_locked_i` and `btn_reset_i` (≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before peripheral reset release (≥1).
- STAGE_GAP_CYCLES, 16: cycles between peripheral release and CPU release (≥1).
- LOCK_TIMEOUT_CYCLES, 1048576: cycles in WAIT_LOCK without lock before a PLL restart (≥2).
- PLL_RST_CYCLES, 8: width of the `pll_rst_o` pulse in cycles (≥1).
- clk  in  1  system clock, taken from a PLL output.
- reset_n  in  1  asynchronous, active-low reset. The only async reset in the block.
- pll_locked_i  in  1  PLL lock, asynchronous to `clk`.
- btn_reset_i  in  1  user reset request, active-high, asynchronous.
- pll_rst_o  out  1  PLL reset request, active-high, registered.
- periph_rst_n_o  out  1  peripheral reset, active-low, registered.
- cpu_rst_n_o  out  1  CPU reset, active-low, registered.
- state_o  out  3  current FSM state encoding: WAIT_LOCK=0, STABLE=1, REL_PERIPH=2, RUN=3, PLL_RESET=4.
- relock_count_o  out  8  number of lock losses seen in RUN, saturating at 255.

## Operation
- `locked_s` and `btn_s` are the inputs after SYNC_STAGES flops. The FSM uses only these synchronized signals.
- One shared cycle counter `cnt` is used; its width covers the largest parameter. It clears on every state transition.
- WAIT_LOCK:
  - Both resets are asserted and `pll_rst_o`=0.
  - If `locked_s`=1, go to STABLE.
  - Otherwise `cnt` increments. When `cnt`==LOCK_TIMEOUT_CYCLES-1, go to PLL_RESET.
- STABLE:
  - Both resets are asserted.
  - If `locked_s`=0, go back to WAIT_LOCK. Lock must be consecutive.
  - Otherwise `cnt` increments. When `cnt`==LOCK_STABLE_CYCLES-1 with `locked_s`=1, go to REL_PERIPH and set `periph_rst_n_o`=1 on the same edge.
- REL_PERIPH:
  - `cnt` increments. When `cnt`==STAGE_GAP_CYCLES-1, go to RUN and set `cpu_rst_n_o`=1 on the same edge.
  - If `locked_s`=0, assert both resets and go to WAIT_LOCK. Do not increment the relock count.
- RUN:
  - Both resets are deasserted.
  - If `locked_s`=0, assert both resets on the next edge, go to WAIT_LOCK, and increment `relock_count_o` (saturating).
- PLL_RESET:
  - `pll_rst_o`=1 and both resets are asserted.
  - `locked_s` is ignored.
  - After PLL_RST_CYCLES cycles, drop `pll_rst_o` and go to WAIT_LOCK.
- Button:
  - `btn_s`=1 in any state other than PLL_RESET forces WAIT_LOCK with both resets asserted and `cnt` cleared. `relock_count_o` does not change.
  - While `btn_s` stays 1, the FSM stays in WAIT_LOCK with `cnt` held at 0, so no timeout can occur.
  - In PLL_RESET the button is ignored until the pulse completes.
- Priority when events coincide: `btn_s` > lock loss > timeout/count completion.
- Resets are always asserted together and released in order: peripheral, then CPU. `cpu_rst_n_o`=1 implies `periph_rst_n_o`=1 on every cycle.

## Timing
- Values during and after `reset_n`=0:
  - state = WAIT_LOCK, `cnt`=0, all synchronizer flops 0.
  - `pll_rst_o`=0, `periph_rst_n_o`=0, `cpu_rst_n_o`=0, `relock_count_o`=0.
- Let edge k be the first edge that samples `pll_locked_i`=1 (lock held from then on):
  - STABLE is entered at edge k+SYNC_STAGES.
  - `periph_rst_n_o` rises at edge k+SYNC_STAGES+LOCK_STABLE_CYCLES.
  - `cpu_rst_n_o` rises STAGE_GAP_CYCLES edges after that.
- Lock loss in RUN, first sampled at edge m: both resets fall at edge m+SYNC_STAGES+1.
- Timeout: PLL_RESET is entered after exactly LOCK_TIMEOUT_CYCLES consecutive WAIT_LOCK cycles without lock. `pll_rst_o` is high for exactly PLL_RST_CYCLES cycles.
- Asserting `reset_n` mid-sequence, including during the `pll_rst_o` pulse, immediately forces all outputs to their reset values.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, STAGE_GAP_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, PLL_RST_CYCLES=8.
- Clean lock: `pll_locked_i` rises, first sampled at edge 10 → `periph_rst_n_o`=1 at edge 28, `cpu_rst_n_o`=1 at edge 32, `state_o`=3.
- Lock glitch: lock high for 8 cycles, low for 1 cycle, then high from edge 30 → `periph_rst_n_o` rises at edge 48. No release occurs earlier.
- Timeout: lock held low after reset release → `pll_rst_o` high for 8 cycles, starting after 64 WAIT_LOCK cycles. The cycle repeats every 72 cycles; resets stay asserted.
- Lock loss in RUN: drop lock at edge m → both resets fall at edge m+3 and `relock_count_o` goes 0→1. Relock re-runs the 16+4 sequence. After 256 losses the count holds at 255.
- Button: pulse `btn_reset_i` for 5 cycles in RUN → resets fall 3 edges after the first sample. Release timing counts from the button's deassertion. `relock_count_o` is unchanged.
- Async reset: assert `reset_n`=0 during the `pll_rst_o` pulse → `pll_rst_o`=0 and `state_o`=0 immediately, without waiting for a clock edge.
